// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/ifu_stream_if.sv
// rtl/ifu_stream_if.sv - fetch unit bus bundle (redirect, imem, decode); IFU_ALIGN_CHECK_EN adds fetch_misalign
interface ifu_stream_if #(
  parameter int ADDR_W = 32
);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus4;
`ifdef IFU_ALIGN_CHECK_EN
  logic              fetch_misalign;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4, fetch_misalign
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4, fetch_misalign
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4
  );
`endif

endinterface

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - circular fetch queue with push, pop and flush (flush wins over pop)
module ifu_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  // popping an empty queue is ignored so count can never underflow
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // entry storage; data needs no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_stream.sv
// rtl/ifu_stream.sv - instruction fetch unit top; IFU_ALIGN_CHECK_EN enables the misaligned-redirect halt
module ifu_stream
  import ifu_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  ifu_stream_if.master bus
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int ENT_W = 32 + ADDR_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              req_valid;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              pending;
  logic              bad_target;

`ifdef IFU_ALIGN_CHECK_EN
  logic outstanding;
  logic misalign;

  assign bad_target         = bus.redirect_pc[1:0] != 2'b00;
  assign pending            = outstanding;
  assign bus.fetch_misalign = misalign;
`else
  assign bad_target = 1'b0;
  assign pending    = (state == WAIT) || (state == DROP);
`endif

  assign req_fire          = req_valid && bus.imem_req_ready;
  assign pop               = bus.out_valid && bus.out_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = !reset && (count != '0);
  assign bus.out_pc         = head[ADDR_W-1:0];
  assign bus.out_instr      = head[ADDR_W +: 32];
  assign bus.out_pc_plus4   = head[ADDR_W-1:0] + ADDR_W'(PC_STEP);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: a redirect overrides everything; an in-flight request must drain through DROP
  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      if (bad_target) begin
        state_nxt = HALT;
      end else if (pending && !bus.imem_rsp_valid) begin
        state_nxt = DROP;
      end else begin
        state_nxt = FETCH;
      end
    end else begin
      case (state)
        FETCH:     if (req_fire) state_nxt = WAIT;
        WAIT,
        DROP:      if (bus.imem_rsp_valid) state_nxt = FETCH;
        default:   state_nxt = state;
      endcase
    end
  end

  // outputs: request only with queue space; accept a response only in WAIT
  always_comb begin
    req_valid = 1'b0;
    push      = 1'b0;
    if (!reset && !bus.redirect_valid) begin
      req_valid = (state == FETCH) && (count < CNT_W'(FQ_DEPTH));
      push      = (state == WAIT) && bus.imem_rsp_valid;
    end
  end

  // program counter, request pc and optional misalign tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= ADDR_W'(RESET_PC);
      req_pc <= ADDR_W'(RESET_PC);
`ifdef IFU_ALIGN_CHECK_EN
      outstanding <= 1'b0;
      misalign    <= 1'b0;
`endif
    end else begin
      if (bus.redirect_valid) begin
        pc <= bus.redirect_pc;
      end else if (push) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
      if (req_fire) begin
        req_pc <= pc;
      end
`ifdef IFU_ALIGN_CHECK_EN
      if (req_fire) begin
        outstanding <= 1'b1;
      end else if (bus.imem_rsp_valid) begin
        outstanding <= 1'b0;
      end
      if (bus.redirect_valid) begin
        misalign <= bad_target;
      end
`endif
    end
  end

  ifu_fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.imem_rsp_data, req_pc}),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head_data (head),
    .count     (count)
  );

endmodule

// File: tb/tb_ifu_stream.sv
// tb/tb_ifu_stream.sv - scoreboard bench for ifu_stream with random memory latency, stalls and redirects
module tb_ifu_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifu_stream_if #(.ADDR_W(32)) bus();

  ifu_stream dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  int          acc_cnt = 0;
  int          ready_mode = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] req_log[$];

  logic        pend = 1'b0;
  int          lat = 0;
  logic [31:0] pend_addr = '0;

  logic        after_flush = 1'b1;
  logic        hold = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    if (idx >= req_log.size()) begin
      total++;
      bad++;
      $display("FAIL %s: no request logged, expected %h", name, exp);
    end else begin
      chk(name, req_log[idx], exp);
    end
  endtask

  // expected decode stream restarts at every reset/redirect target
  task automatic refill(input logic [31:0] base);
    exp_q.delete();
    exp_next = base;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    refill(32'h0000_3000);
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    refill(t);
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    int base;
    base = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_cnt > base) return;
    end
    total++;
    bad++;
    $display("FAIL %s: no request accepted within 20 cycles", name);
  endtask

  // keep the expected stream topped up: sequential word addresses from the last target
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() < 16) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
    end
  end

  // instruction memory: one outstanding request, latency lat_min..lat_max
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_rsp_valid) pend = 1'b0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = bus.imem_req_addr;
        lat       = $urandom_range(lat_max, lat_min);
        acc_cnt++;
        req_log.push_back(bus.imem_req_addr);
      end
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (pend && lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(pend_addr);
        end
      end
      bus.imem_req_ready = !pend && (ready_mode == 0 ||
                                     (ready_mode == 1 && $urandom_range(0, 3) != 0));
    end
  end

  // monitor: compares every decode handshake against the expected stream
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        after_flush = 1'b1;
        hold        = 1'b0;
      end else begin
        if (after_flush) chk("flush_empty", 32'(bus.out_valid), 32'd0);
        if (hold) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_pc", bus.out_pc, hold_pc);
          chk("hold_instr", bus.out_instr, hold_instr);
        end
        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got pc %h, expected no output", bus.out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", bus.out_pc, e);
            chk("out_instr", bus.out_instr, mem_word(e));
            chk("out_pc_plus4", bus.out_pc_plus4, e + 32'd4);
            n_out++;
          end
        end
        after_flush = bus.redirect_valid;
        hold        = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
        hold_pc     = bus.out_pc;
        hold_instr  = bus.out_instr;
      end
    end
  end

  // stimulus
  initial begin
    int b;
    logic [31:0] r;
    logic [31:0] t;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    refill(32'h0000_3000);

    // straight-line fetch with 1-cycle memory
    b = req_log.size();
    do_reset(3);
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0000_3000);
    repeat (12) step();
    chk_log("seq_req0", b, 32'h0000_3000);
    chk_log("seq_req1", b + 1, 32'h0000_3004);
    chk_log("seq_req2", b + 2, 32'h0000_3008);

    // decode stalled: queue fills to depth 2 then requests stop
    bus.out_ready = 1'b0;
    do_reset(2);
    b = req_log.size();
    repeat (12) step();
    @(negedge clk);
    chk("full_req_count", 32'(req_log.size() - b), 32'd2);
    chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_head_pc", bus.out_pc, 32'h0000_3000);
    step();
    bus.out_ready = 1'b1;
    repeat (10) step();
    chk_log("resume_req", b + 2, 32'h0000_3008);

    // redirect while waiting on a slow response
    lat_min = 3;
    lat_max = 3;
    do_reset(2);
    wait_accept("wait_redirect");
    redirect(32'h0000_3100);
    b = req_log.size();
    repeat (15) step();
    chk_log("redir_wait_req", b, 32'h0000_3100);

    // redirect in the same cycle as the response
    lat_min = 1;
    lat_max = 1;
    do_reset(2);
    wait_accept("rsp_redirect");
    redirect(32'h0000_3200);
    b = req_log.size();
    repeat (12) step();
    chk_log("redir_rsp_req", b, 32'h0000_3200);

    // memory not ready: request held stable, no progress
    ready_mode = 2;
    do_reset(2);
    b = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("stall_req_addr", bus.imem_req_addr, 32'h0000_3000);
      step();
    end
    chk("stall_no_accept", 32'(acc_cnt - b), 32'd0);
    ready_mode = 0;

    // reset while waiting: the late response must be ignored
    lat_min = 3;
    lat_max = 3;
    wait_accept("reset_wait");
    b = req_log.size();
    do_reset(1);
    @(negedge clk);
    chk("reset_mid_pc", bus.imem_req_addr, 32'h0000_3000);
    repeat (15) step();
    chk_log("reset_mid_req", b, 32'h0000_3000);

`ifdef IFU_ALIGN_CHECK_EN
    lat_min = 1;
    lat_max = 2;
    do_reset(2);
    repeat (6) step();
    redirect(32'h0000_3102);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_misalign", 32'(bus.fetch_misalign), 32'd1);
      chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("halt_out_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    redirect(32'h0000_3200);
    @(negedge clk);
    chk("halt_clear", 32'(bus.fetch_misalign), 32'd0);
    b = req_log.size();
    repeat (12) step();
    chk_log("halt_resume_req", b, 32'h0000_3200);
`endif

    // randomized traffic
    ready_mode = 1;
    lat_min    = 1;
    lat_max    = 4;
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom;
      if (r[12:4] == 9'd0) begin
        do_reset(1);
      end else if (r[31:27] == 5'd0) begin
        if (r[1:0] == 2'd0) t = 32'hFFFF_FFF0 + {28'd0, r[3:2], 2'b00};
        else                t = {16'd0, r[26:13], 2'b00};
        redirect(t);
      end else begin
        step();
      end
    end
    bus.out_ready = 1'b1;
    repeat (20) step();
    total++;
    if (n_out < 300) begin
      bad++;
      $display("FAIL progress: got %0d outputs expected at least 300", n_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_stream.md
Name: ifu_stream

Overview:
- Parametrised next-generation instruction fetch unit for the MIPS core.
- Holds the PC and issues word fetches to an instruction memory over a valid/ready request and valid-only response interface, so memory latency may vary.
- Buffers returned words in a small fetch queue and presents {instr, pc, pc+4} to decode with a valid/ready handshake.
- Control flow (beq/jal/jr and later additions) is resolved downstream and arrives as a single redirect.

Parameters:
- ADDR_W, 32, PC / address width in bits (>=8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset (truncated to ADDR_W).
- FQ_DEPTH, 2, fetch-queue entries; power of 2, >=2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc this cycle.
- redirect_pc  in  ADDR_W  new fetch address.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  word address of the request (the current PC).
- imem_rsp_valid  in  1  response data valid; exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode consumes the head.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  head PC.
- out_pc_plus4  out  ADDR_W  head PC + 4, modulo 2^ADDR_W.

Behaviour:
- Decided: one clock (clk); reset is synchronous and active-high (reset).
- Reset:
  - pc=RESET_PC; queue empty; state FETCH.
  - imem_req_valid=0 and out_valid=0 while reset is high.
  - First request, at RESET_PC, is raised in the first cycle after reset deasserts.
  - Reset has priority over every other input, including mid-transaction.
  - A response arriving in the cycle after reset is ignored, because state is FETCH.
- Single outstanding request. State machine:
  - FETCH:
    - imem_req_valid = (count + 0 < FQ_DEPTH) && !redirect_valid.
    - On req handshake: go to WAIT and latch req_pc=pc.
  - WAIT:
    - No request issued.
    - On imem_rsp_valid: push {data, req_pc} into the queue, set pc <= pc+4, go to FETCH.
  - DROP:
    - No request issued.
    - On imem_rsp_valid: discard the data, go to FETCH.
- Space rule: a push in WAIT is guaranteed space, because the request was only issued when count < FQ_DEPTH.
- Queue:
  - Circular buffer with wr/rd pointers and a count of 0..FQ_DEPTH.
  - Pointers wrap modulo FQ_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - out_* is driven combinationally from the head entry; out_valid = (count != 0).
  - Head fields hold stable while out_valid && !out_ready.
- Redirect (any state, highest priority after reset):
  - Queue flushed (count=0) and pc <= redirect_pc.
  - A pop in the same cycle is void.
  - From FETCH: go to FETCH; no request is raised in the redirect cycle.
  - From WAIT with no response this cycle: go to DROP.
  - From WAIT with a response this cycle: the response is discarded, go to FETCH.
  - From DROP: stay in DROP, or go to FETCH if a response arrives this cycle.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W.
- Nominal throughput with 1-cycle memory: one instruction every 2 cycles.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit), reset to 0.
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misalign=1, loads pc, and parks the FSM in a HALT state.
  - In HALT, no requests are issued and the queue stays empty.
  - Only reset or a later aligned redirect clears fetch_misalign and leaves HALT.
- Undefined: no port, no check; low PC bits pass through unchanged.

Decomposition:
- Package ifu_pkg holds:
  - FSM state encoding: FETCH, WAIT, DROP, HALT.
  - Default RESET_PC constant.
  - Constant PC_STEP=4.
- One sub-module, ifu_fetch_queue: parametrised FIFO (width 32+ADDR_W, depth FQ_DEPTH) with push, pop and flush; pop and flush take effect on the same edge, with flush winning.

Test Plan:
- Reset then 1-cycle memory, out_ready=1 → requests at 0x3000, 0x3004, 0x3008; out_pc/out_pc_plus4 read 0x3000/0x3004, then 0x3004/0x3008.
- out_ready=0 with FQ_DEPTH=2 → exactly 2 words queued, imem_req_valid stays 0; on release, words pop in order and fetch resumes at 0x3008.
- Redirect to 0x3100 while in WAIT with a 3-cycle response → stale word dropped; next request at 0x3100; out_pc is first 0x3100.
- Redirect and imem_rsp_valid in the same cycle, and redirect with a pop in the same cycle → no stale output; queue is empty the next cycle.
- imem_req_ready held low for 4 cycles → imem_req_addr stable at 0x3000 and no state advance; reset asserted mid-WAIT → pc=0x3000, out_valid=0, the late response is ignored.
- With IFU_ALIGN_CHECK_EN: redirect to 0x3102 → fetch_misalign=1, no requests; a following redirect to 0x3200 clears it and fetch resumes at 0x3200.
